// File: rtl/fb_arbiter.sv
// Framebuffer memory arbiter: scanout prefetch FIFO vs. raster writes on a single port.
// Define FB_ARB_UNDERRUN_EN to build the sticky scanout underrun detector.
module fb_arbiter #(
   parameter int unsigned ADDR_W     = 20,
   parameter int unsigned FB_WORDS   = 480000,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LOW_WATER  = 4,
   parameter int unsigned READ_LAT   = 2
) (
   input  logic              pixel_clock,
   input  logic              rst,
   input  logic              scan_start,
   input  logic              scan_pop,
   output logic [23:0]       scan_pixel,
   output logic              scan_empty,
   output logic              scan_underrun,
   input  logic              rast_req,
   input  logic [ADDR_W-1:0] rast_addr,
   input  logic [23:0]       rast_wdata,
   output logic              rast_gnt,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [23:0]       mem_wdata,
   input  logic [23:0]       mem_rdata
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + READ_LAT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StFlush
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
   logic [READ_LAT-1:0] rd_sr_q, rd_sr_d;
   logic [23:0]         fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
   logic [OCC_W-1:0]    inflight, occupancy;
   logic                rd_issue, wr_issue, last_fetch, push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Each bit is one read in flight; the MSB is the read whose data is on mem_rdata now.
   if (READ_LAT > 1) begin : g_sr_multi
      assign rd_sr_d = {rd_sr_q[READ_LAT-2:0], rd_issue};
   end else begin : g_sr_single
      assign rd_sr_d = rd_issue;
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(READ_LAT); i++) begin
         inflight = inflight + OCC_W'(rd_sr_q[i]);
      end
      occupancy = OCC_W'(fifo_cnt_q) + inflight;
   end

   assign scan_empty = (fifo_cnt_q == '0);
   assign last_fetch = (fetch_addr_q == ADDR_W'(FB_WORDS - 1));

   // Returning data is dropped while flushing a previous frame's reads.
   assign push = rd_sr_q[READ_LAT-1] && (state_q != StFlush) && !scan_start;
   assign pop  = scan_pop && !scan_empty && !scan_start;

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      rd_issue     = 1'b0;
      wr_issue     = 1'b0;
      unique case (state_q)
         StActive: begin
            if (!scan_start && (occupancy < OCC_W'(LOW_WATER))) begin
               rd_issue = 1'b1;
            end else if (rast_req) begin
               wr_issue = 1'b1;
            end else if (!scan_start && (occupancy < OCC_W'(FIFO_DEPTH))) begin
               rd_issue = 1'b1;
            end
            if (rd_issue) begin
               if (last_fetch) begin
                  state_d = StIdle;
               end else begin
                  fetch_addr_d = fetch_addr_q + ADDR_W'(1);
               end
            end
         end
         StFlush: begin
            wr_issue = rast_req;
            if (inflight == '0) begin
               state_d = StActive;
            end
         end
         default: begin
            wr_issue = rast_req;
         end
      endcase
      if (scan_start) begin
         fetch_addr_d = '0;
         state_d      = (inflight != '0) ? StFlush : StActive;
      end
   end

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (scan_start) begin
         fifo_cnt_d = '0;
      end else if (push && !pop) begin
         fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
         fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      end
   end

   assign mem_cs     = rd_issue | wr_issue;
   assign mem_we     = wr_issue;
   assign mem_addr   = wr_issue ? rast_addr : (rd_issue ? fetch_addr_q : '0);
   assign mem_wdata  = wr_issue ? rast_wdata : '0;
   assign rast_gnt   = wr_issue;
   assign scan_pixel = scan_empty ? '0 : fifo_mem[rd_ptr_q];

   always_ff @(posedge pixel_clock) begin
      if (rst) begin
         state_q      <= StIdle;
         fetch_addr_q <= '0;
         rd_sr_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         rd_sr_q      <= rd_sr_d;
         fifo_cnt_q   <= fifo_cnt_d;
         if (scan_start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
               rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
         end
      end
   end

   always_ff @(posedge pixel_clock) begin
      if (!rst && push) begin
         fifo_mem[wr_ptr_q] <= mem_rdata;
      end
   end

`ifdef FB_ARB_UNDERRUN_EN
   logic underrun_q;

   always_ff @(posedge pixel_clock) begin
      if (rst || scan_start) begin
         underrun_q <= 1'b0;
      end else if (scan_pop && scan_empty) begin
         underrun_q <= 1'b1;
      end
   end

   assign scan_underrun = underrun_q;
`else
   assign scan_underrun = 1'b0;
`endif

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20: framebuffer word address width.
REQ-002 Parameter FB_WORDS, default 480000: words per frame (800x600, one 24-bit pixel per word).
REQ-003 Parameter FIFO_DEPTH, default 16: scanout prefetch FIFO entries; power of two.
REQ-004 Parameter LOW_WATER, default 4: occupancy below which scanout reads preempt raster writes.
REQ-005 Parameter READ_LAT, default 2: fixed memory read latency in cycles.
REQ-006 pixel_clock  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 scan_start  in  1  frame-start pulse: restart fetch at address 0 and flush the FIFO.
REQ-009 scan_pop  in  1  consume the FIFO head pixel.
REQ-010 scan_pixel  out  24  FIFO head {R,G,B}; first-word fall-through; valid while scan_empty=0.
REQ-011 scan_empty  out  1  FIFO empty.
REQ-012 scan_underrun  out  1  sticky flag: pop attempted while empty.
REQ-013 rast_req  in  1  raster write request; addr/data held stable until granted.
REQ-014 rast_addr  in  ADDR_W  raster write address.
REQ-015 rast_wdata  in  24  raster write pixel.
REQ-016 rast_gnt  out  1  one-cycle pulse; the write issues to memory this cycle.
REQ-017 mem_cs  out  1  memory command valid; at most one command per cycle.
REQ-018 mem_we  out  1  1 = write, 0 = read; qualified by mem_cs.
REQ-019 mem_addr  out  ADDR_W  command address.
REQ-020 mem_wdata  out  24  write data (= rast_wdata on a write).
REQ-021 mem_rdata  in  24  read data, valid exactly READ_LAT cycles after the read issues.

Function
REQ-022 The FSM SHALL have states IDLE, ACTIVE and FLUSH.
REQ-023 scan_start in any state SHALL clear the FIFO, set fetch_addr to 0, and go to FLUSH if reads are in flight, else to ACTIVE.
REQ-024 FLUSH SHALL discard returning read data and go to ACTIVE once in-flight reads reach 0.
REQ-025 ACTIVE SHALL go to IDLE in the cycle the read of FB_WORDS-1 issues; fetch_addr SHALL NOT wrap or exceed FB_WORDS-1.
REQ-026 Occupancy SHALL equal fifo_count plus in-flight reads; in-flight tracking SHALL use a READ_LAT-deep valid shift register.
REQ-027 ACTIVE per-cycle priority SHALL be:
- (1) read if occupancy < LOW_WATER;
- (2) write if rast_req;
- (3) read if occupancy < FIFO_DEPTH;
- (4) no command.
REQ-028 IDLE and FLUSH SHALL issue a write if rast_req, else no command.
REQ-029 mem_* and rast_gnt SHALL assert in the decision cycle with no added latency.
REQ-030 A read issued in cycle N SHALL capture mem_rdata at the end of cycle N+READ_LAT into the FIFO.
REQ-031 The FIFO SHALL never overflow, by occupancy reservation.
REQ-032 Pop while empty SHALL be ignored; simultaneous push and pop SHALL leave the count unchanged.
REQ-033 scan_start with scan_pop in the same cycle: the flush SHALL win, the pop SHALL be ignored and SHALL NOT flag underrun.
REQ-034 Deasserting rast_req before grant SHALL be legal and produce no grant.
REQ-035 Writes with addr >= FB_WORDS SHALL be issued unchecked.

Reset
REQ-036 While rst=1 at a clock edge, the block SHALL enter IDLE with an empty FIFO, fetch_addr=0, the in-flight register cleared and scan_underrun=0.
REQ-037 After reset, mem_cs, mem_we, rast_gnt and scan_underrun SHALL be 0, and scan_empty SHALL be 1.
REQ-038 mem_addr, mem_wdata and scan_pixel SHALL be 0 after reset.
REQ-039 Reads in flight at reset SHALL be discarded.

Configuration
REQ-040 With FB_ARB_UNDERRUN_EN defined, scan_underrun SHALL set on any pop-while-empty (except per REQ-033) and clear only on rst or scan_start.
REQ-041 With FB_ARB_UNDERRUN_EN undefined, scan_underrun SHALL be constant 0 and no detection logic SHALL exist.

Verification
REQ-042 rst, then scan_start at cycle 0, no pops, no rast_req -> reads of addresses 0..15 issue in cycles 1..16, then mem_cs=0; scan_empty=0 from cycle 4; pops return data of addresses 0..15 in order.
REQ-043 FIFO full, rast_req with addr 0x00100 and data 0xFF00DE -> same cycle: rast_gnt=1, mem_cs=1, mem_we=1, mem_addr=0x00100, mem_wdata=0xFF00DE; rast_gnt=0 the next cycle.
REQ-044 Occupancy 3 with rast_req held -> reads issue and rast_gnt stays 0 until occupancy reaches 4; then the write is granted.
REQ-045 scan_start with 2 reads in flight -> FLUSH; returned data discarded; next read at addr 0; first popped pixel is data of addr 0.
REQ-046 FB_WORDS=8 -> exactly 8 reads, state IDLE; 8 pops drain, then scan_empty=1; a 9th pop sets scan_underrun=1 with the macro and leaves it 0 without it.
REQ-047 scan_start and scan_pop in the same cycle on an empty FIFO -> scan_underrun stays 0; FIFO empty; fetch restarts at 0.
